// File: rtl/ac_tdm_interface.sv
// ac_tdm_interface -- audio serial master for I2S, left-justified and TDM
// (DSP short-sync) codecs. Generates MCLK/BCLK/frame sync, serialises CH_NUM
// DAC words and deserialises CH_NUM ADC words per frame.
//
// Ports:
//   clk         master clock, forwarded as audMclk
//   reset       asynchronous active-low reset
//   cmdModEn    module enable; low aborts the frame and clears everything
//   audMclk     clk gated by cmdModEn and reset
//   audBclk     bit clock, BCLK_DIVIDER clk periods
//   audFs       LRCK (I2S/LJ) or one-bit frame-sync pulse (TDM)
//   audAdcData  serial ADC data from the codec
//   audDacData  serial DAC data to the codec
//   tick        one-clk pulse at each frame start
//   adcData     CH_NUM packed signed samples, channel k at [k*DATA_WDT +: DATA_WDT]
//   genData     CH_NUM packed signed DAC samples, same packing
//   overrun     sticky: genData changed in the tick cycle (latch cycle)
//
// Build option: define AC_TDM_LOOPBACK_EN to feed the ADC deserialiser from
// the internal audDacData register instead of the audAdcData pin.
module ac_tdm_interface #(
   parameter string MODE         = "I2S",
   parameter int    CH_NUM       = 2,
   parameter int    DATA_WDT     = 24,
   parameter int    SLOT_WDT     = 32,
   parameter int    BCLK_DIVIDER = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         cmdModEn,
   output logic                         audMclk,
   output logic                         audBclk,
   output logic                         audFs,
   input  logic                         audAdcData,
   output logic                         audDacData,
   output logic                         tick,
   output logic [CH_NUM*DATA_WDT-1:0]   adcData,
   input  logic [CH_NUM*DATA_WDT-1:0]   genData,
   output logic                         overrun
);
   localparam bit IS_I2S = (MODE == "I2S");
   localparam bit IS_LJ  = (MODE == "LEFT-JUSTIFIED");
   localparam bit IS_TDM = (MODE == "TDM");
   localparam int DLY    = IS_I2S ? 1 : 0;
   localparam int DIV_W  = $clog2(BCLK_DIVIDER);
   localparam int CH_W   = $clog2(CH_NUM);
   localparam int SLOT_W = $clog2(SLOT_WDT);
   localparam int BIT_W  = $clog2(DATA_WDT);

   if (!(IS_I2S || IS_LJ || IS_TDM)) begin : g_bad_mode
      $error("ac_tdm_interface: MODE must be I2S, LEFT-JUSTIFIED or TDM");
   end
   if (CH_NUM < 2 || CH_NUM > 8 || (!IS_TDM && (CH_NUM % 2) != 0)) begin : g_bad_ch
      $error("ac_tdm_interface: CH_NUM out of range or odd for I2S/LJ");
   end
   if (DATA_WDT < 16 || DATA_WDT > 32 || SLOT_WDT < DATA_WDT + DLY) begin : g_bad_wdt
      $error("ac_tdm_interface: DATA_WDT/SLOT_WDT combination invalid");
   end
   if (BCLK_DIVIDER < 2 || (BCLK_DIVIDER % 2) != 0) begin : g_bad_div
      $error("ac_tdm_interface: BCLK_DIVIDER must be even and >= 2");
   end

   typedef logic [CH_NUM-1:0][DATA_WDT-1:0] frame_t;

   logic [DIV_W-1:0]  cnt_bclk;
   logic [CH_W-1:0]   cnt_ch;     // channel slot of the bit launched on the next fall
   logic [SLOT_W-1:0] cnt_slot;   // bit within that slot
   frame_t            shadow, adc_shift, adc_q, adc_next, gen_f, dac_word;
   logic              launch_vld; // previous launched bit carried a data bit
   logic [CH_W-1:0]   launch_ch;
   logic [BIT_W-1:0]  launch_bit;

   logic fall, at_bit0, frame_start, cur_data, upper_half, fs_next, dac_bit, adc_in;
   logic [BIT_W-1:0] cur_bit;
   int               slot_pos;

   // Gated MCLK forward; purely combinational so it stops as soon as enable
   // or reset drops.
   assign audMclk = clk & cmdModEn & reset;

   assign gen_f       = genData;
   assign adcData     = adc_q;
   assign fall        = (cnt_bclk == DIV_W'(BCLK_DIVIDER / 2));
   assign at_bit0     = (cnt_ch == '0) && (cnt_slot == '0);
   assign frame_start = fall && at_bit0;

   // Position decode of the bit about to be launched.
   assign slot_pos   = int'(cnt_slot);
   assign cur_data   = (slot_pos >= DLY) && (slot_pos < DLY + DATA_WDT);
   assign cur_bit    = BIT_W'(DATA_WDT - 1 + DLY - slot_pos);
   assign upper_half = int'(cnt_ch) >= CH_NUM / 2;
   assign fs_next    = IS_TDM ? at_bit0 : (IS_I2S ? upper_half : !upper_half);

   // The shadow is loaded on the same strobe that launches bit 0, so bit 0
   // comes straight from genData.
   assign dac_word = at_bit0 ? gen_f : shadow;
   assign dac_bit  = cur_data ? dac_word[cnt_ch][cur_bit] : 1'b0;

`ifdef AC_TDM_LOOPBACK_EN
   logic unused_adc_pin;
   assign unused_adc_pin = audAdcData;
   assign adc_in         = audDacData;
`else
   assign adc_in = audAdcData;
`endif

   // Sample of the previously launched bit merged in; at frame start this
   // merged value goes to adcData so a bit landing on the wrap strobe is kept.
   always_comb begin
      adc_next = adc_shift;
      if (fall && launch_vld) adc_next[launch_ch][launch_bit] = adc_in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_bclk   <= '0;
         cnt_ch     <= '0;
         cnt_slot   <= '0;
         audBclk    <= 1'b0;
         audFs      <= 1'b0;
         audDacData <= 1'b0;
         tick       <= 1'b0;
         overrun    <= 1'b0;
         shadow     <= '0;
         adc_shift  <= '0;
         adc_q      <= '0;
         launch_vld <= 1'b0;
         launch_ch  <= '0;
         launch_bit <= '0;
      end else if (!cmdModEn) begin
         cnt_bclk   <= '0;
         cnt_ch     <= '0;
         cnt_slot   <= '0;
         audBclk    <= 1'b0;
         audFs      <= 1'b0;
         audDacData <= 1'b0;
         tick       <= 1'b0;
         overrun    <= 1'b0;
         shadow     <= '0;
         adc_shift  <= '0;
         adc_q      <= '0;
         launch_vld <= 1'b0;
         launch_ch  <= '0;
         launch_bit <= '0;
      end else begin
         cnt_bclk <= (cnt_bclk == DIV_W'(BCLK_DIVIDER - 1)) ? '0 : cnt_bclk + DIV_W'(1);
         if (cnt_bclk == '0) audBclk <= 1'b1;
         else if (fall)      audBclk <= 1'b0;
         tick <= frame_start;
         // tick high means the shadow was loaded on the previous edge; any
         // difference now is an update the DAC frame missed.
         if (tick && (gen_f != shadow)) overrun <= 1'b1;
         if (fall) begin
            if (cnt_slot == SLOT_W'(SLOT_WDT - 1)) begin
               cnt_slot <= '0;
               cnt_ch   <= (cnt_ch == CH_W'(CH_NUM - 1)) ? '0 : cnt_ch + CH_W'(1);
            end else begin
               cnt_slot <= cnt_slot + SLOT_W'(1);
            end
            audFs      <= fs_next;
            audDacData <= dac_bit;
            launch_vld <= cur_data;
            launch_ch  <= cnt_ch;
            launch_bit <= cur_bit;
            adc_shift  <= adc_next;
            if (at_bit0) begin
               shadow <= gen_f;
               adc_q  <= adc_next;
            end
         end
      end
   end
endmodule

// File: tb/tb_ac_tdm_interface.sv
// Bench for ac_tdm_interface: three configurations (I2S 2x24/32 div4,
// TDM 8x16/16 div2, LJ 4x32/32 div6) run side by side against a reference
// model that derives every pin value from the clock count since enable.
module tb_ac_tdm_interface;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic [255:0] gen_v [3];
   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_cfg
      localparam int MD  = g;   // 0 I2S, 1 TDM, 2 LJ
      localparam int CH  = (g == 0) ? 2  : (g == 1) ? 8  : 4;
      localparam int DW  = (g == 0) ? 24 : (g == 1) ? 16 : 32;
      localparam int SW  = (g == 0) ? 32 : (g == 1) ? 16 : 32;
      localparam int DIV = (g == 0) ? 4  : (g == 1) ? 2  : 6;
      localparam int DL  = (g == 0) ? 1  : 0;
      localparam int FB  = CH * SW;
      localparam int W   = CH * DW;

      logic bclk, fs, dac, tk, ovr, mclk;
      logic adc_in = 1'b0;
      logic [W-1:0] adc_out, gen;
      assign gen = gen_v[g][W-1:0];

      if (g == 0) begin : g_dut
         ac_tdm_interface #(.MODE("I2S"), .CH_NUM(CH), .DATA_WDT(DW), .SLOT_WDT(SW),
                            .BCLK_DIVIDER(DIV)) u_dut (
            .clk(clk), .reset(rst_n), .cmdModEn(en), .audMclk(mclk), .audBclk(bclk),
            .audFs(fs), .audAdcData(adc_in), .audDacData(dac), .tick(tk),
            .adcData(adc_out), .genData(gen), .overrun(ovr));
      end else if (g == 1) begin : g_dut
         ac_tdm_interface #(.MODE("TDM"), .CH_NUM(CH), .DATA_WDT(DW), .SLOT_WDT(SW),
                            .BCLK_DIVIDER(DIV)) u_dut (
            .clk(clk), .reset(rst_n), .cmdModEn(en), .audMclk(mclk), .audBclk(bclk),
            .audFs(fs), .audAdcData(adc_in), .audDacData(dac), .tick(tk),
            .adcData(adc_out), .genData(gen), .overrun(ovr));
      end else begin : g_dut
         ac_tdm_interface #(.MODE("LEFT-JUSTIFIED"), .CH_NUM(CH), .DATA_WDT(DW),
                            .SLOT_WDT(SW), .BCLK_DIVIDER(DIV)) u_dut (
            .clk(clk), .reset(rst_n), .cmdModEn(en), .audMclk(mclk), .audBclk(bclk),
            .audFs(fs), .audAdcData(adc_in), .audDacData(dac), .tick(tk),
            .adcData(adc_out), .genData(gen), .overrun(ovr));
      end

      // Serial value of frame bit c for a packed word: data MSB first at
      // slot bits DL..DL+DW-1, zero elsewhere.
      function automatic logic bit_at(input logic [W-1:0] w, input int c);
         int ch, sb;
         ch = c / SW;
         sb = c % SW;
         if (sb < DL || sb >= DL + DW) return 1'b0;
         return w[ch*DW + DW - 1 - (sb - DL)];
      endfunction

      function automatic logic fs_at(input int c);
         if (MD == 1) return c == 0;
         if (MD == 0) return (c / SW) >= CH / 2;
         return (c / SW) < CH / 2;
      endfunction

      function automatic logic [W-1:0] new_codec();
         logic [W-1:0] r;
         for (int k = 0; k < CH; k++)
            r[k*DW +: DW] = (MD == 1) ? DW'(16'hA5C3 + k) : DW'($urandom);
         return r;
      endfunction

      int t = -1;        // enabled clock edges seen minus one
      int cl = 0;        // frame position launched on the latest fall
      logic e_tick = 1'b0, e_fs = 1'b0, e_dac = 1'b0, e_ovr = 1'b0, prev_tick = 1'b0;
      logic [W-1:0] word_q = '0, prev_word = '0, codec = '0, e_adc = '0;

      initial begin
         forever begin
            @(posedge clk);
            prev_tick = e_tick;
            if (!rst_n || !en) begin
               t = -1; cl = 0;
               e_tick = 1'b0; e_fs = 1'b0; e_dac = 1'b0; e_ovr = 1'b0;
               e_adc = '0; word_q = '0;
            end else begin : run
               int f;
               t++;
               if (prev_tick && gen != word_q) e_ovr = 1'b1;
               e_tick = 1'b0;
               if (t % DIV == DIV / 2) begin
                  f  = t / DIV;
                  cl = f % FB;
                  if (cl == 0) begin
                     e_tick    = 1'b1;
                     prev_word = word_q;
                     word_q    = gen;
`ifdef AC_TDM_LOOPBACK_EN
                     e_adc = (f == 0) ? '0 : prev_word;
`else
                     e_adc = (f == 0) ? '0 : codec;
`endif
                     codec = new_codec();
                  end
                  e_fs  = fs_at(cl);
                  e_dac = bit_at(word_q, cl);
               end
            end
            #1;
            chk($sformatf("c%0d_mclk", g), mclk, en & rst_n);
            adc_in = (t >= 0) ? bit_at(codec, cl) : 1'b0;
            @(negedge clk);
            chk($sformatf("c%0d_bclk", g), bclk, (rst_n && t >= 0) ? ((t % DIV) < DIV / 2) : 1'b0);
            chk($sformatf("c%0d_fs", g), fs, rst_n ? e_fs : 1'b0);
            chk($sformatf("c%0d_dac", g), dac, rst_n ? e_dac : 1'b0);
            chk($sformatf("c%0d_tick", g), tk, rst_n ? e_tick : 1'b0);
            chk($sformatf("c%0d_ovr", g), ovr, rst_n ? e_ovr : 1'b0);
            chk($sformatf("c%0d_adc", g), adc_out, rst_n ? e_adc : '0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic hit;
      gen_v[0] = {208'd0, 24'h800001, 24'h7FFFFE};
      gen_v[1] = rnd256();
      gen_v[2] = {128'd0, {4{32'h80000000}}};
      step(3);
      chk("rst_tick", g_cfg[0].tk, 1'b0);
      chk("rst_adc", g_cfg[0].adc_out, '0);
      rst_n = 1'b1;
      step(2);
      en = 1'b1;
      n = 0;
      while (!g_cfg[0].tk && n < 50) begin step(1); n++; end
      chk("first_tick_clks", n, 3);
      step(800);

`ifdef AC_TDM_LOOPBACK_EN
      hit = 1'b0;
      for (int i = 0; i < 400 && !hit; i++) begin step(1); hit = g_cfg[0].tk; end
      chk("loop_tick_seen", hit, 1'b1);
      chk("loop_adc", g_cfg[0].adc_out, gen_v[0][47:0]);
`else
      hit = 1'b0;
      for (int i = 0; i < 400 && !hit; i++) begin step(1); hit = g_cfg[1].tk; end
      chk("tdm_tick_seen", hit, 1'b1);
      chk("tdm_slot7", g_cfg[1].adc_out[7*16 +: 16], 16'hA5CA);
`endif

      // random genData updates kept clear of the latch cycles
      for (int k = 0; k < 20; k++) begin
         step($urandom_range(30, 150));
         for (int j = 0; j < 4 && (g_cfg[0].tk || g_cfg[1].tk || g_cfg[2].tk); j++) step(1);
         for (int i = 0; i < 3; i++) gen_v[i] = rnd256();
      end

      // abort mid-frame
      hit = 1'b0;
      for (int i = 0; i < 1100 && !hit; i++) begin step(1); hit = (g_cfg[0].cl == 37); end
      chk("bit37_seen", hit, 1'b1);
      en = 1'b0;
      step(1);
      chk("abort_bclk", g_cfg[0].bclk, 1'b0);
      chk("abort_fs", g_cfg[0].fs, 1'b0);
      chk("abort_adc", g_cfg[0].adc_out, '0);
      step(5);
      en = 1'b1;
      n = 0;
      while (!g_cfg[0].tk && n < 50) begin step(1); n++; end
      chk("reen_tick_clks", n, 3);
      step(600);

      // asynchronous reset mid-frame
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_tick", g_cfg[0].tk, 1'b0);
      chk("arst_fs", g_cfg[1].fs, 1'b0);
      chk("arst_dac", g_cfg[2].dac, 1'b0);
      chk("arst_adc", g_cfg[0].adc_out, '0);
      chk("arst_mclk", g_cfg[0].mclk, 1'b0);
      step(2);
      rst_n = 1'b1;
      n = 0;
      while (!g_cfg[0].tk && n < 50) begin step(1); n++; end
      chk("rst_tick_clks", n, 3);
      step(300);

      // overrun
      chk("ovr_clear", g_cfg[0].ovr, 1'b0);
      hit = 1'b0;
      for (int i = 0; i < 400 && !hit; i++) begin step(1); hit = g_cfg[0].tk; end
      chk("ovr_tick_seen", hit, 1'b1);
      gen_v[0][0] = ~gen_v[0][0];
      step(1);
      chk("ovr_set", g_cfg[0].ovr, 1'b1);
      step(400);
      chk("ovr_sticky", g_cfg[0].ovr, 1'b1);
      en = 1'b0;
      step(1);
      chk("ovr_cleared", g_cfg[0].ovr, 1'b0);
      step(3);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
